// File: rtl/cmp_max_search.sv
// Streams elements through the registered magnitude comparator to find the running maximum, its first index and tie count.
// Each element after the first costs 3 cycles: accept, comparator sample, flag evaluation. in_ready is high only in FIRST/FETCH.
module cmp_max_search #(
  parameter int WORD  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WORD-1:0]  in_data,
  output logic             in_ready,
  output logic [WORD-1:0]  cmp_a,
  output logic [WORD-1:0]  cmp_b,
  input  logic             cmp_e,
  input  logic             cmp_h,
  input  logic             cmp_l,
  output logic             busy,
  output logic             done,
  output logic [WORD-1:0]  max_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] tie_cnt,
  output logic             flag_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_FETCH,
    S_WAIT,
    S_EVAL,
    S_FIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cand_idx;
  logic             accept;
  logic             onehot;

  assign accept = in_valid && in_ready;
  assign onehot = ({cmp_e, cmp_h, cmp_l} == 3'b100) ||
                  ({cmp_e, cmp_h, cmp_l} == 3'b010) ||
                  ({cmp_e, cmp_h, cmp_l} == 3'b001);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (len == '0) ? S_FIN : S_FIRST;
      S_FIRST: if (accept) state_nx = (len_q == CNT_W'(1)) ? S_FIN : S_FETCH;
      S_FETCH: if (accept) state_nx = S_WAIT;
      S_WAIT:  state_nx = S_EVAL;
      S_EVAL:  state_nx = (idx == len_q) ? S_FIN : S_FETCH;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_FIRST) || (state == S_FETCH);
    busy     = (state != S_IDLE);
    done     = (state == S_FIN);
  end

  // cmp_a/cmp_b only move in FIRST/FETCH/EVAL, so they are stable while the comparator samples them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q    <= '0;
      idx      <= '0;
      cand_idx <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      max_val  <= '0;
      max_idx  <= '0;
      tie_cnt  <= '0;
      flag_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= len;
            idx      <= '0;
            cand_idx <= '0;
            max_val  <= '0;
            max_idx  <= '0;
            tie_cnt  <= '0;
            flag_err <= 1'b0;
          end
        end
        S_FIRST: begin
          if (accept) begin
            max_val <= in_data;
            cmp_b   <= in_data;
            idx     <= CNT_W'(1);
          end
        end
        S_FETCH: begin
          if (accept) begin
            cmp_a    <= in_data;
            cand_idx <= idx;
            idx      <= idx + 1'b1;
          end
        end
        S_EVAL: begin
          // Malformed flags are recorded and the candidate is discarded like a smaller value.
          if (!onehot) begin
            flag_err <= 1'b1;
          end else if (cmp_h) begin
            max_val <= cmp_a;
            cmp_b   <= cmp_a;
            max_idx <= cand_idx;
            tie_cnt <= '0;
          end else if (cmp_e && (tie_cnt != '1)) begin
            tie_cnt <= tie_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_max_search.sv
// Bench for cmp_max_search: directed table, reset-abort sequence and randomized searches against a declarative max/tie model.
module tb_cmp_max_search;
  localparam int WORD  = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WORD-1:0]  in_data;
  logic             in_ready;
  logic [WORD-1:0]  cmp_a;
  logic [WORD-1:0]  cmp_b;
  logic             cmp_e = 1'b0;
  logic             cmp_h = 1'b0;
  logic             cmp_l = 1'b0;
  logic             busy;
  logic             done;
  logic [WORD-1:0]  max_val;
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] tie_cnt;
  logic             flag_err;

  cmp_max_search #(.WORD(WORD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_e(cmp_e), .cmp_h(cmp_h), .cmp_l(cmp_l),
    .busy(busy), .done(done), .max_val(max_val), .max_idx(max_idx),
    .tie_cnt(tie_cnt), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int inj_target = -1;
  logic inj_pend = 1'b0;
  logic [7:0] stim [256];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Registered comparator; a chosen handshake makes its compare return E and H together.
  always @(posedge clk) begin
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    inj_pend <= in_valid && in_ready && (hs_cnt == inj_target);
    if (inj_pend) begin
      cmp_e <= 1'b1; cmp_h <= 1'b1; cmp_l <= 1'b0;
    end else begin
      cmp_e <= (cmp_a == cmp_b); cmp_h <= (cmp_a > cmp_b); cmp_l <= (cmp_a < cmp_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Maximum over the non-discarded elements, its first position, and how many later copies exist.
  function automatic void ref_model(input int n, input int inj, output logic [7:0] m,
                                    output int mi, output int t, output bit err);
    int best;
    m = 8'd0; mi = 0; t = 0; best = -1;
    err = (inj > 0) && (inj < n);
    for (int i = 0; i < n; i++)
      if (!(err && i == inj) && int'(stim[i]) > best) best = int'(stim[i]);
    if (n == 0) return;
    m = 8'(best);
    for (int i = n - 1; i >= 0; i--)
      if (!(err && i == inj) && stim[i] == m) mi = i;
    for (int i = mi + 1; i < n; i++)
      if (!(err && i == inj) && stim[i] == m) t++;
    if (t > 255) t = 255;
  endfunction

  task automatic run_search(input int n, input int gap_at, input int gap_len, input int inj,
                            input bit glitch, input logic [7:0] e_max, input int e_idx,
                            input int e_tie, input bit e_err, input int e_lat);
    int s, w, d0;
    logic [7:0] a, b;
    inj_target = (inj > 0) ? hs_cnt + inj : -1;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; len = CNT_W'(n);
    @(negedge clk);
    start = 1'b0; s = cyc;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          chk("stall_ready", in_ready, 1);
          if (glitch && g == 0) begin start = 1'b1; len = CNT_W'(1); end
          @(negedge clk);
          start = 1'b0;
        end
      end
      in_valid = 1'b1; in_data = stim[i];
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      if (w >= 20) begin chk("ready_timeout", 0, 1); in_valid = 1'b0; return; end
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'($urandom);
      if (i > 0) begin
        chk("wait_ready", in_ready, 0);
        chk("wait_cmp_a", cmp_a, stim[i]);
        a = cmp_a; b = cmp_b;
        @(negedge clk);
        chk("eval_ready", in_ready, 0);
        chk("eval_cmp_a", cmp_a, a);
        chk("eval_cmp_b", cmp_b, b);
        @(negedge clk);
      end
    end
    w = 0;
    while (done !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("done_seen", done, 1);
    chk("latency", cyc - s + 1, e_lat);
    chk("max_val", max_val, e_max);
    chk("max_idx", max_idx, e_idx);
    chk("tie_cnt", tie_cnt, e_tie);
    chk("flag_err", flag_err, e_err);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("idle_busy", busy, 0);
    chk("held_max", max_val, e_max);
    @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
  endtask

  typedef struct {
    int          n;
    logic [0:7][7:0] v;
    int          gap_at;
    int          gap_len;
    int          inj;
    bit          glitch;
    logic [7:0]  e_max;
    int          e_idx;
    int          e_tie;
    bit          e_err;
    int          e_lat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] m;
    int mi, t, n, ga, gl, inj, lat, d0;
    bit err;

    tbl[0] = '{4, {8'd3, 8'd9, 8'd2, 8'd9, 32'd0}, 99, 0, 0, 1'b0, 8'd9, 1, 1, 1'b0, 11};
    tbl[1] = '{3, {8'd5, 8'd7, 8'd255, 40'd0}, 99, 0, 0, 1'b0, 8'd255, 2, 0, 1'b0, 8};
    tbl[2] = '{0, 64'd0, 99, 0, 0, 1'b0, 8'd0, 0, 0, 1'b0, 1};
    tbl[3] = '{1, {8'd42, 56'd0}, 99, 0, 0, 1'b0, 8'd42, 0, 0, 1'b0, 2};
    tbl[4] = '{3, {8'd4, 8'd1, 8'd6, 40'd0}, 1, 5, 0, 1'b1, 8'd6, 2, 0, 1'b0, 13};
    tbl[5] = '{4, {8'd1, 8'd5, 8'd8, 8'd5, 32'd0}, 99, 0, 2, 1'b0, 8'd5, 1, 1, 1'b1, 11};
    tbl[6] = '{3, {8'd0, 8'd0, 8'd0, 40'd0}, 99, 0, 0, 1'b0, 8'd0, 0, 2, 1'b0, 8};
    tbl[7] = '{4, {8'd7, 8'd7, 8'd8, 8'd8, 32'd0}, 99, 0, 0, 1'b0, 8'd8, 2, 1, 1'b0, 11};
    tbl[8] = '{3, {8'd200, 8'd100, 8'd50, 40'd0}, 99, 0, 0, 1'b0, 8'd200, 0, 0, 1'b0, 8};

    reset = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_cmp_b", cmp_b, 0);
    chk("rst_flag_err", flag_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 8; j++) stim[j] = tbl[k].v[j];
      run_search(tbl[k].n, tbl[k].gap_at, tbl[k].gap_len, tbl[k].inj, tbl[k].glitch,
                 tbl[k].e_max, tbl[k].e_idx, tbl[k].e_tie, tbl[k].e_err, tbl[k].e_lat);
    end

    // Abort a search while the comparator is sampling, then confirm a clean restart.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; len = CNT_W'(3);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'd10;
    @(negedge clk);
    in_data = 8'd20;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_abort_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_max_val", max_val, 0);
    chk("abort_cmp_a", cmp_a, 0);
    chk("abort_cmp_b", cmp_b, 0);
    chk("abort_max_idx", max_idx, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      if (c == 1) reset = 1'b1;
    end
    chk("abort_done_count", done_cnt - d0, 0);
    for (int j = 0; j < 8; j++) stim[j] = tbl[0].v[j];
    run_search(4, 99, 0, 0, 1'b0, 8'd9, 1, 1, 1'b0, 11);

    for (int r = 0; r < 24; r++) begin
      n = (r == 23) ? 200 : int'($urandom_range(1, 12));
      for (int j = 0; j < n; j++)
        stim[j] = (r % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      inj = (r % 4 == 3 && n > 1) ? int'($urandom_range(1, n - 1)) : 0;
      ga = int'($urandom_range(0, 15));
      gl = int'($urandom_range(0, 3));
      ref_model(n, inj, m, mi, t, err);
      lat = ((n == 1) ? 2 : 3 * n - 1) + ((ga < n) ? gl : 0);
      run_search(n, ga, gl, inj, 1'b0, m, mi, t, err, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
